// File: rtl/lsu_data_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_data_port_pkg
//  Brief    : Shared funct3 codes, FSM state encoding and access-legality
//             helper for the load/store data port.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_data_port_pkg;

  // RV32 load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } lsu_state_e;

  // Misaligned halfword/word, reserved funct3, or unsigned-width store.
  function automatic logic access_error(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic r;
    case (funct3)
      F3_B:  r = 1'b0;
      F3_BU: r = we;
      F3_H:  r = offset[0];
      F3_HU: r = offset[0] | we;
      F3_W:  r = (offset != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_data_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_data_port_if
//  Brief    : Request/response bundle toward the datapath plus the word-wide
//             sync-read memory port. slave = LSU side, master = datapath and
//             memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_data_port_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_w_en;
  logic [31:0]           mem_w_data;
  logic [31:0]           mem_r_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_data,
    output busy, done, err, rdata, mem_addr, mem_w_en, mem_w_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_data,
    input  busy, done, err, rdata, mem_addr, mem_w_en, mem_w_data
  );
endinterface
`default_nettype wire

// File: rtl/lsu_data_port_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_data_port_byte_lane
//  Brief    : Combinational lane logic: extracts and extends a byte/halfword
//             from a memory word for loads, and splices store data into the
//             old word for sub-word read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_data_port_byte_lane
  import lsu_data_port_pkg::*;
(
  input  wire logic [31:0] word,
  input  wire logic [31:0] wdata,
  input  wire logic [1:0]  offset,
  input  wire logic [2:0]  funct3,
  output logic      [31:0] load_data,
  output logic      [31:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it according to the load width.
  always_comb begin
    w_byte    = word[{offset, 3'b000} +: 8];
    w_half    = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'd0, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'd0, w_half};
      default: load_data = word;
    endcase
  end

  // Replace only the addressed lane of the old word with the store data.
  always_comb begin
    merge_data = word;
    case (funct3[1:0])
      2'b00: merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (offset[1]) merge_data[31:16] = wdata[15:0];
        else           merge_data[15:0]  = wdata[15:0];
      end
      2'b10:   merge_data = wdata;
      default: merge_data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_data_port.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_data_port
//  Brief    : RV32 load/store unit in front of a word-only sync-read memory.
//             Sub-word stores use read-modify-write; illegal or misaligned
//             accesses complete immediately with err and no memory access.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic        clk,
  input  wire logic        reset,
  lsu_data_port_if.slave   bus
);

  lsu_state_e              r_state;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [1:0]              r_offset;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_w_data;

  logic                    w_err;
  logic [31:0]             w_load_data;
  logic [31:0]             w_merge_data;
  logic                    w_unused_addr_hi;

  // Address bits above the memory window wrap and carry no meaning.
  assign w_unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH];

  assign w_err = access_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  lsu_data_port_byte_lane u_lane (
    .word       (bus.mem_r_data),
    .wdata      (r_wdata),
    .offset     (r_offset),
    .funct3     (r_funct3),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_RESP);
  assign bus.err        = r_err;
  assign bus.rdata      = r_rdata;
  assign bus.mem_addr   = r_mem_addr;
  // Gated by reset so the edge that applies reset never commits a write.
  assign bus.mem_w_en   = (r_state == S_WR) && !reset;
  assign bus.mem_w_data = r_mem_w_data;

  // Access sequencer: latch request, walk read/merge/write, pulse completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_offset     <= 2'd0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_w_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_funct3   <= bus.req_funct3;
            r_offset   <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
            r_err      <= w_err;
            r_rdata    <= '0;
            r_mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (w_err) begin
              r_state <= S_RESP;
            end else if (bus.req_we && bus.req_funct3 == F3_W) begin
              r_mem_w_data <= bus.req_wdata;
              r_state      <= S_WR;
            end else begin
              r_state <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: r_state <= S_RD_DATA;
        S_RD_DATA: begin
          if (r_we) begin
            r_mem_w_data <= w_merge_data;
            r_state      <= S_WR;
          end else begin
            r_rdata <= w_load_data;
            r_state <= S_RESP;
          end
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
